// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: shared sizing for the RAM-backed FIFO controller.
// AW/DW match the 256x16 dual-port RAM the controller drives.
package ram_fifo_pkg;
   localparam int AW    = 8;
   localparam int DW    = 16;
   localparam int DEPTH = 2**AW;

   // Word count covering RAM + in-flight read + output buffer (max DEPTH+2).
   typedef logic [AW:0] level_t;
endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: push and pop streams of the FIFO controller.
// Handshake: a word moves on a rising edge where valid & ready are both 1.
// The source holds valid and data steady until that transfer. On the pop
// side, valid never drops before its word has been taken.
interface ram_fifo_ctrl_if import ram_fifo_pkg::*; #(parameter int WIDTH = DW);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (output in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_data);
   modport slave  (input  in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_data);
endinterface

// File: rtl/ram_fifo_obuf.sv
// ram_fifo_obuf: 2-entry first-word-fall-through buffer behind the RAM read
// port. Slot 0 is the head. A pop shifts slot 1 down. A captured word lands in
// the first free slot that remains after that shift.
module ram_fifo_obuf #(
   parameter int DW = ram_fifo_pkg::DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          capture,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [1:0]    ob_cnt,
   output logic          valid,
   output logic [DW-1:0] head
);
   logic [DW-1:0] ob0, ob1, ob0_n, ob1_n;
   logic [1:0]    cnt_after;

   // Next-slot contents: shift on pop, then place the captured word.
   always_comb begin
      cnt_after = ob_cnt - {1'b0, pop};
      ob0_n     = ob0;
      ob1_n     = ob1;
      // Only shift when a second word exists, so an emptied head keeps its
      // last value instead of showing stale slot 1.
      if (pop && ob_cnt == 2'd2) ob0_n = ob1;
      if (capture) begin
         if (cnt_after == 2'd0) ob0_n = din;
         else                   ob1_n = din;
      end
   end

   // Buffer registers; reset and flush discard everything and zero the head.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         ob_cnt <= 2'd0;
         ob0    <= '0;
         ob1    <= '0;
      end else begin
         ob_cnt <= cnt_after + {1'b0, capture};
         ob0    <= ob0_n;
         ob1    <= ob1_n;
      end
   end

   assign valid = (ob_cnt != 2'd0);
   assign head  = ob0;
endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller driving an external 256x16 dual-port RAM.
// The RAM has a one-cycle registered read. Pointers and counts live here, and
// the output buffer hides the read latency.
// Optional: define RAM_FIFO_PEAK_EN to build the peak_level high watermark.
// Without it, peak_level is tied to 0.
module ram_fifo_ctrl #(
   parameter int AW = ram_fifo_pkg::AW,
   parameter int DW = ram_fifo_pkg::DW
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   ram_fifo_ctrl_if.slave bus,
   output logic [AW:0]    level,
   output logic [AW:0]    peak_level,
   output logic           ram_wr,
   output logic [AW-1:0]  ram_w_addr,
   output logic [DW-1:0]  ram_din,
   output logic [AW-1:0]  ram_r_addr,
   input  logic [DW-1:0]  ram_dout
);
   localparam logic [AW:0] FULL = (AW+1)'(2**AW);

   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   ram_cnt;
   logic          inflight;
   logic [1:0]    ob_cnt;
   logic          push_fire, pop_fire, issue;
   logic [2:0]    occ;

   // Handshakes, read issue decision and RAM port drive.
   always_comb begin
      bus.in_ready = rst_n & ~flush & (ram_cnt < FULL);
      push_fire    = bus.in_valid & bus.in_ready;
      pop_fire     = bus.out_valid & bus.out_ready;
      // Issue only when the word will have a free buffer slot on arrival.
      occ          = {1'b0, ob_cnt} + {2'b0, inflight};
      issue        = (ram_cnt != '0) && (occ < (3'd2 + {2'b0, pop_fire}));
      ram_wr       = push_fire;
      ram_w_addr   = wptr;
      ram_din      = bus.in_data;
      ram_r_addr   = rptr;
      level        = ram_cnt + {{AW{1'b0}}, inflight} + {{(AW-1){1'b0}}, ob_cnt};
   end

   // Pointer and occupancy state. An in-flight read is dropped by reset/flush.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wptr     <= '0;
         rptr     <= '0;
         ram_cnt  <= '0;
         inflight <= 1'b0;
      end else begin
         if (push_fire) wptr <= wptr + 1'b1;
         if (issue)     rptr <= rptr + 1'b1;
         ram_cnt  <= ram_cnt + {{AW{1'b0}}, push_fire} - {{AW{1'b0}}, issue};
         inflight <= issue;
      end
   end

   ram_fifo_obuf #(.DW(DW)) u_obuf (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .capture (inflight),
      .din     (ram_dout),
      .pop     (pop_fire),
      .ob_cnt  (ob_cnt),
      .valid   (bus.out_valid),
      .head    (bus.out_data)
   );

`ifdef RAM_FIFO_PEAK_EN
   logic [AW:0] peak_q;

   // High watermark of level, restarted by reset or flush.
   always_ff @(posedge clk) begin
      if (!rst_n || flush)   peak_q <= '0;
      else if (level > peak_q) peak_q <= level;
   end

   assign peak_level = peak_q;
`else
   assign peak_level = '0;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: randomized and directed bench for ram_fifo_ctrl.
// The reference model is a word queue plus a write count. Expected level,
// order, addresses and watermark all come from that queue.
module tb_ram_fifo_ctrl;
   import ram_fifo_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   level_t        level, peak_level;
   logic          ram_wr;
   logic [AW-1:0] ram_w_addr, ram_r_addr;
   logic [DW-1:0] ram_din, ram_dout;
   logic [DW-1:0] mem [DEPTH];

   ram_fifo_ctrl_if #(.WIDTH(DW)) bus ();

   ram_fifo_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .bus        (bus),
      .level      (level),
      .peak_level (peak_level),
      .ram_wr     (ram_wr),
      .ram_w_addr (ram_w_addr),
      .ram_din    (ram_din),
      .ram_r_addr (ram_r_addr),
      .ram_dout   (ram_dout)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // 256x16 RAM with a registered read, as the integrator would attach it.
   always @(posedge clk) begin
      if (ram_wr) mem[ram_w_addr] <= ram_din;
      ram_dout <= mem[ram_r_addr];
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard state
   int            n_checks = 0;
   int            n_fail = 0;
   logic [DW-1:0] exp_q[$];
   int            wr_total = 0;
   level_t        model_peak = '0;
   bit            last_push = 1'b0;
   bit            last_pop = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One clock cycle: score the cycle just before the edge, then step past it.
   task automatic tick();
      int sz;
      @(negedge clk);
      sz = exp_q.size();
      check_eq("level", 32'(level), 32'(sz));
`ifdef RAM_FIFO_PEAK_EN
      check_eq("peak", 32'(peak_level), 32'(model_peak));
`else
      check_eq("peak_off", 32'(peak_level), 32'd0);
`endif
      if (!rst_n || flush) begin
         check_eq("ready_in_clear", 32'(bus.in_ready), 32'd0);
         exp_q.delete();
         wr_total   = 0;
         model_peak = '0;
         last_push  = 1'b0;
         last_pop   = 1'b0;
      end else begin
         if (sz < DEPTH) check_eq("in_ready_room", 32'(bus.in_ready), 32'd1);
         if (sz == DEPTH + 2) check_eq("in_ready_full", 32'(bus.in_ready), 32'd0);
         if (32'(sz) > 32'(model_peak)) model_peak = level_t'(sz);
         last_pop  = bus.out_valid && bus.out_ready;
         last_push = bus.in_valid && bus.in_ready;
         if (last_pop) begin
            if (exp_q.size() == 0) check_eq("pop_on_empty", 32'd1, 32'd0);
            else check_eq("pop_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
         end
         if (last_push) begin
            check_eq("ram_wr", 32'(ram_wr), 32'd1);
            check_eq("ram_w_addr", 32'(ram_w_addr), 32'(wr_total % DEPTH));
            check_eq("ram_din", 32'(ram_din), 32'(bus.in_data));
            exp_q.push_back(bus.in_data);
            wr_total++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // driver tasks
   task automatic fill(input int n, input int start);
      int acc = 0;
      int nxt = start;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      for (int c = 0; c < 2 * n + 20 && acc < n; c++) begin
         bus.in_data = DW'(nxt);
         tick();
         if (last_push) begin
            acc++;
            nxt++;
         end
      end
      bus.in_valid = 1'b0;
      check_eq("fill_count", 32'(acc), 32'(n));
   endtask

   task automatic drain(input int budget);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < budget && exp_q.size() > 0; c++) tick();
      bus.out_ready = 1'b0;
      check_eq("drain_done", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_valid(input int budget);
      for (int c = 0; c < budget && !bus.out_valid; c++) tick();
      check_eq("valid_timeout", 32'(bus.out_valid), 32'd1);
   endtask

   initial begin
      int pushed, popped, bubbles;
      bit started;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
      check_eq("rst_level", 32'(level), 32'd0);
      check_eq("rst_ram_wr", 32'(ram_wr), 32'd0);
      check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
      rst_n = 1'b1;
      #1;
      check_eq("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

      // single push and its two-edge latency
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hA5A5;
      #1;
      check_eq("e0_ram_wr", 32'(ram_wr), 32'd1);
      check_eq("e0_w_addr", 32'(ram_w_addr), 32'd0);
      check_eq("e0_din", 32'(ram_din), 32'hA5A5);
      tick();
      bus.in_valid = 1'b0;
      check_eq("lat_e0_valid", 32'(bus.out_valid), 32'd0);
      tick();
      check_eq("lat_e1_valid", 32'(bus.out_valid), 32'd0);
      tick();
      check_eq("lat_e2_valid", 32'(bus.out_valid), 32'd1);
      check_eq("lat_e2_data", 32'(bus.out_data), 32'hA5A5);
      check_eq("lat_e2_level", 32'(level), 32'd1);
      drain(10);

      // fill to total capacity, reject one more, drain in order
      fill(DEPTH + 2, 0);
      check_eq("full_level", 32'(level), 32'(DEPTH + 2));
      check_eq("full_in_ready", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hDEAD;
      tick();
      bus.in_valid = 1'b0;
      check_eq("full_reject", 32'(last_push), 32'd0);
      drain(DEPTH + 20);
      tick();
      check_eq("empty_valid", 32'(bus.out_valid), 32'd0);
      check_eq("empty_hold", 32'(bus.out_data), 32'(DEPTH + 1));

      // continuous push and pop: one word per cycle once data arrives
      pushed = 0; popped = 0; bubbles = 0; started = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 1000 && popped < 600; c++) begin
         bus.in_valid = (pushed < 600);
         bus.in_data  = DW'($urandom);
         tick();
         if (last_push) pushed++;
         if (last_pop) begin
            popped++;
            started = 1'b1;
         end else if (started && popped < 600) begin
            bubbles++;
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check_eq("stream_pops", 32'(popped), 32'd600);
      check_eq("stream_bubbles", 32'(bubbles), 32'd0);

      // random traffic
      for (int c = 0; c < 600; c++) begin
         bus.in_valid  = ($urandom_range(0, 99) < 60);
         bus.out_ready = ($urandom_range(0, 99) < 50);
         bus.in_data   = DW'($urandom);
         tick();
      end
      drain(DEPTH + 20);

      // flush with a push pending
      fill(100, 1000);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hFFFF;
      flush        = 1'b1;
      #1;
      check_eq("flush_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      check_eq("flush_level", 32'(level), 32'd0);
      check_eq("flush_valid", 32'(bus.out_valid), 32'd0);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h1234;
      #1;
      check_eq("flush_w_addr", 32'(ram_w_addr), 32'd0);
      tick();
      bus.in_valid = 1'b0;
      wait_valid(5);
      check_eq("flush_readback", 32'(bus.out_data), 32'h1234);
      drain(10);

      // reset while a read is in flight
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hBEEF;
      tick();
      bus.in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      check_eq("rstfl_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rstfl_data", 32'(bus.out_data), 32'd0);
      check_eq("rstfl_level", 32'(level), 32'd0);

      // watermark
      fill(37, 50);
      drain(60);
      tick();
`ifdef RAM_FIFO_PEAK_EN
      check_eq("peak_hold", 32'(peak_level), 32'd37);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_eq("peak_flush", 32'(peak_level), 32'd0);
`else
      check_eq("peak_tied", 32'(peak_level), 32'd0);
`endif

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
